// File: rtl/dvi_timing_gen.sv
// DVI/VGA raster timing generator: programmable porch/sync/active lengths,
// continuous or one-shot frames, and a stop that lets the current frame finish.
module dvi_timing_gen #(
   parameter int CW        = 12,
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic          oneshot,
   output logic          hsync_out,
   output logic          vsync_out,
   output logic          ve,
   output logic [CW-1:0] x_out,
   output logic [CW-1:0] y_out,
   output logic          line_start,
   output logic          frame_start,
   output logic          busy
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] ZERO     = {CW{1'b0}};
   localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;
   logic          mode_q, mode_d;
   logic          stop_pend_q, stop_pend_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          ve_q, ve_d;
   logic          line_q, line_d;
   logic          frame_q, frame_d;
   logic          busy_q, busy_d;

   // Next-state: raster counters, stop bookkeeping and frame-end decision
   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      v_d         = v_q;
      mode_d      = mode_q;
      stop_pend_d = stop_pend_q;
      case (state_q)
         ST_IDLE: begin
            h_d         = ZERO;
            v_d         = ZERO;
            stop_pend_d = 1'b0;
            if (start) begin
               state_d = ST_RUN;
               mode_d  = oneshot;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // stop dominates a simultaneous start
            if (stop) begin
               stop_pend_d = 1'b1;
            end else if (start) begin
               stop_pend_d = 1'b0;
            end else begin
               stop_pend_d = stop_pend_q;
            end
            if (h_q == H_LAST) begin
               h_d = ZERO;
               if (v_q == V_LAST) begin
                  v_d = ZERO;
                  if (stop_pend_q || mode_q) begin
                     state_d     = ST_IDLE;
                     stop_pend_d = 1'b0;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  v_d = v_q + ONE;
               end
            end else begin
               h_d = h_q + ONE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            h_d         = ZERO;
            v_d         = ZERO;
            stop_pend_d = 1'b0;
         end
      endcase
   end

   // Output decode from next-state so registered outputs line up with the counters
   always_comb begin
      busy_d  = (state_d == ST_RUN);
      ve_d    = busy_d && (h_d < H_ACT) && (v_d < V_ACT);
      line_d  = busy_d && (h_d == ZERO);
      frame_d = busy_d && (h_d == ZERO) && (v_d == ZERO);
      if (busy_d && (h_d >= HS_BEG) && (h_d < HS_END)) begin
         hsync_d = HSYNC_POL;
      end else begin
         hsync_d = ~HSYNC_POL;
      end
      if (busy_d && (v_d >= VS_BEG) && (v_d < VS_END)) begin
         vsync_d = VSYNC_POL;
      end else begin
         vsync_d = ~VSYNC_POL;
      end
   end

   // State, counter and output registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         h_q         <= ZERO;
         v_q         <= ZERO;
         mode_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         hsync_q     <= ~HSYNC_POL;
         vsync_q     <= ~VSYNC_POL;
         ve_q        <= 1'b0;
         line_q      <= 1'b0;
         frame_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         v_q         <= v_d;
         mode_q      <= mode_d;
         stop_pend_q <= stop_pend_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         ve_q        <= ve_d;
         line_q      <= line_d;
         frame_q     <= frame_d;
         busy_q      <= busy_d;
      end
   end

   assign hsync_out   = hsync_q;
   assign vsync_out   = vsync_q;
   assign ve          = ve_q;
   assign x_out       = h_q;
   assign y_out       = v_q;
   assign line_start  = line_q;
   assign frame_start = frame_q;
   assign busy        = busy_q;

endmodule

// File: doc/dvi_timing_gen.md
Name: dvi_timing_gen

Overview:
- Parametrised successor to dvi_stimulate: a DVI/VGA raster timing generator with programmable horizontal and vertical porch, sync and active lengths, and per-axis sync polarity.
- Supports continuous and one-shot frame modes, plus a graceful stop that completes the current frame.
- Exports pixel coordinates and line/frame strobes so downstream pixel fetch and the DVI encoder can lock to the raster.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync_out (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync_out
- CW, 12, counter/coordinate width; must satisfy 2^CW >= H_TOTAL and 2^CW >= V_TOTAL

Ports:
- clock  in  1  single system/pixel clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin raster generation (level sampled each cycle)
- stop  in  1  request stop at end of current frame
- oneshot  in  1  sampled with accepted start; 1 = emit exactly one frame
- hsync_out  out  1  horizontal sync, polarity HSYNC_POL
- vsync_out  out  1  vertical sync, polarity VSYNC_POL
- ve  out  1  video enable (active region)
- x_out  out  CW  horizontal counter value
- y_out  out  CW  vertical counter value
- line_start  out  1  high for the h=0 cycle of every line while running
- frame_start  out  1  high for the h=0, v=0 cycle while running
- busy  out  1  high while in RUN

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active, front porch, sync, back porch. Vertical order is the same, in lines.
- States:
  - IDLE: h=v=0; no counting.
  - RUN: h increments each cycle. At h=H_TOTAL-1, h wraps to 0 and v increments. At v=V_TOTAL-1 with h=H_TOTAL-1, v wraps to 0.
- Reset (reset=0 at a rising edge):
  - state IDLE, h=v=0, stop_pending=0, mode=0.
  - hsync_out=~HSYNC_POL, vsync_out=~VSYNC_POL; ve, line_start, frame_start, busy = 0; x_out=y_out=0.
  - Applies mid-frame with no completion.
- IDLE -> RUN: on an edge where start=1.
  - h=v=0; oneshot captured into mode.
  - First active pixel (x=0, y=0, ve=1, frame_start=1) is presented in the cycle following that edge.
- Start while in RUN does not restart the raster.
- stop_pending in RUN:
  - stop=1 sets stop_pending (stop wins when start=1 in the same cycle).
  - start=1 with stop=0 clears a pending stop.
- Frame end (h=H_TOTAL-1, v=V_TOTAL-1): if stop_pending or mode=1, go to IDLE with counters and stop_pending cleared; else wrap to (0,0).
- stop in IDLE is ignored.
- Output decode (registered, cycle-aligned with x_out/y_out):
  - ve = RUN && h<H_ACTIVE && v<V_ACTIVE.
  - hsync asserted when RUN && H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted when RUN && V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines (changes at h=0).
  - In IDLE: syncs at deasserted level, ve=0, strobes=0, x_out=y_out=0.
- x_out/y_out show raw counter values, including blanking.
- Frame length in RUN: exactly H_TOTAL*V_TOTAL cycles.

Test Plan (small config: H 4/1/2/1 -> H_TOTAL=8; V 3/1/1/1 -> V_TOTAL=6; frame = 48 cycles; POL=0):
- Reset held 3 cycles, then released with start=0 -> hsync=vsync=1, ve=0, busy=0, x=y=0 indefinitely.
- start pulse, oneshot=0:
  - next cycle frame_start=1, ve=1, x=0, y=0.
  - ve high for x=0..3 on y=0..2; hsync=0 at x=5,6 on every line; vsync=0 for all of y=4.
  - frame_start recurs every 48 cycles.
- start with oneshot=1 -> exactly 48 busy cycles, then IDLE; syncs return to 1, x=y=0.
- stop asserted at y=1, x=2 during continuous run -> frame completes to (7,5); busy drops the next cycle; no further frame_start.
- stop and start high together mid-frame -> stop_pending set, IDLE at frame end. A later start alone mid-frame (stop=0) before frame end cancels the stop, and running continues.
- reset=0 at y=4, x=5 (syncs asserted) -> next cycle all outputs at reset values; a subsequent start begins at (0,0).
